// File: rtl/ztj_vending_fsm.sv
// ztj_vending_fsm
// Vending controller for a 1.5-unit item that accepts 0.5-unit and 1.0-unit coins.
// A Mealy machine and a Moore machine track the same credit in parallel. Each one
// raises a dispense flag. Registered copies of both flags are provided so that
// downstream logic can use glitch-free versions.
module ztj_vending_fsm (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] D_in,
  output logic       D_out_mealy,
  output logic       D_out_moore,
  output logic       D_out_reg_mealy,
  output logic       D_out_reg_mealy_adv,
  output logic       D_out_reg_moore,
  output logic       D_out_reg_moore_adv
);

  // Moore credit states. S3 means the item is paid for and is being dispensed.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } moore_state_e;

  // Mealy credit states. Encoding 2'd3 is unused and recovers to M0.
  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2
  } mealy_state_e;

  moore_state_e moore_q, moore_d;
  mealy_state_e mealy_q, mealy_d;

  logic mealy_adv_q;
  logic mealy_reg_q;
  logic moore_reg_q;
  logic moore_adv_q;

  // Decode the coin code. 2'b00 and 2'b11 carry no value.
  logic coin_half;
  logic coin_one;
  assign coin_half = (D_in == 2'b01);
  assign coin_one  = (D_in == 2'b10);

  // The Mealy dispense flag fires on the edge that completes payment.
  // It follows D_in combinationally.
  assign D_out_mealy = ((mealy_q == M1) && coin_one) ||
                       ((mealy_q == M2) && (coin_one || coin_half));

  // The Moore dispense flag is decoded directly from a state register.
  assign D_out_moore = (moore_q == S3);

  assign D_out_reg_mealy_adv = mealy_adv_q;
  assign D_out_reg_mealy     = mealy_reg_q;
  assign D_out_reg_moore     = moore_reg_q;
  assign D_out_reg_moore_adv = moore_adv_q;

  // Next-state logic for both machines.
  always_comb begin
    // NOTE: each variable gets a default before the case statements. This way
    // every path assigns it, and the tool does not infer a latch.
    moore_d = S0;
    mealy_d = M0;

    case (moore_q)
      S0, S3: begin
        if (coin_one)       moore_d = S2;
        else if (coin_half) moore_d = S1;
        else                moore_d = S0;
      end
      S1: begin
        if (coin_one)       moore_d = S3;
        else if (coin_half) moore_d = S2;
        else                moore_d = S1;
      end
      S2: begin
        // Paying 2.0 in total still dispenses. The 0.5 excess is forfeited.
        if (coin_one || coin_half) moore_d = S3;
        else                       moore_d = S2;
      end
      default: moore_d = S0;
    endcase

    case (mealy_q)
      M0: begin
        if (coin_one)       mealy_d = M2;
        else if (coin_half) mealy_d = M1;
        else                mealy_d = M0;
      end
      M1: begin
        if (coin_one)       mealy_d = M0;
        else if (coin_half) mealy_d = M2;
        else                mealy_d = M1;
      end
      M2: begin
        if (coin_one || coin_half) mealy_d = M0;
        else                       mealy_d = M2;
      end
      default: mealy_d = M0;
    endcase
  end

  // State registers and registered dispense flags. Reset clears all credit.
  // NOTE: the reset is asynchronous, so rst has its own event in the
  // sensitivity list. State is updated with non-blocking assignments so that
  // every register samples the values from before the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      moore_q     <= S0;
      mealy_q     <= M0;
      mealy_adv_q <= 1'b0;
      mealy_reg_q <= 1'b0;
      moore_reg_q <= 1'b0;
      moore_adv_q <= 1'b0;
    end else begin
      moore_q     <= moore_d;
      mealy_q     <= mealy_d;
      mealy_adv_q <= D_out_mealy;
      mealy_reg_q <= mealy_adv_q;
      moore_reg_q <= D_out_moore;
      moore_adv_q <= (moore_d == S3);
    end
  end

endmodule

// File: tb/tb_ztj_vending_fsm.sv
// tb_ztj_vending_fsm
// Directed vector bench for the vending FSM. Each vector holds one coin code and
// the six output values expected while that code is applied, before the edge.
// Output order: {mealy, moore, reg_mealy, reg_mealy_adv, reg_moore, reg_moore_adv}.
module tb_ztj_vending_fsm;

  logic       Clk;
  logic       Reset;
  logic [1:0] D_in;
  logic       D_out_mealy;
  logic       D_out_moore;
  logic       D_out_reg_mealy;
  logic       D_out_reg_mealy_adv;
  logic       D_out_reg_moore;
  logic       D_out_reg_moore_adv;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] din;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  ztj_vending_fsm dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .D_in                (D_in),
    .D_out_mealy         (D_out_mealy),
    .D_out_moore         (D_out_moore),
    .D_out_reg_mealy     (D_out_reg_mealy),
    .D_out_reg_mealy_adv (D_out_reg_mealy_adv),
    .D_out_reg_moore     (D_out_reg_moore),
    .D_out_reg_moore_adv (D_out_reg_moore_adv)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [5:0] outs();
    return {D_out_mealy, D_out_moore, D_out_reg_mealy,
            D_out_reg_mealy_adv, D_out_reg_moore, D_out_reg_moore_adv};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one coin code and check the outputs at the falling edge.
  // Then advance past the next rising edge.
  task automatic step(input logic [1:0] din, input logic [5:0] exp, input string name);
    D_in = din;
    @(negedge Clk);
    check(name, outs(), exp);
    // The lookahead Moore flag and the advanced Mealy flag must both track D_out_moore.
    check({name, "_moore_adv_align"}, {5'b0, D_out_reg_moore_adv}, {5'b0, exp[4]});
    check({name, "_mealy_adv_align"}, {5'b0, D_out_reg_mealy_adv}, {5'b0, exp[4]});
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // 0.5 + 0.5 + 0.5: the Mealy flag is high in the 3rd cycle, Moore in the 4th,
    // and the registered Moore flag in the 5th.
    vecs.push_back('{2'b01, 6'b000000});
    vecs.push_back('{2'b01, 6'b000000});
    vecs.push_back('{2'b01, 6'b100000});
    vecs.push_back('{2'b00, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b00, 6'b000000});
    // 1.0 then 0.5
    vecs.push_back('{2'b10, 6'b000000});
    vecs.push_back('{2'b01, 6'b100000});
    vecs.push_back('{2'b00, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b00, 6'b000000});
    // 1.0 then 1.0 (overpay). A following single 0.5 must not dispense.
    vecs.push_back('{2'b10, 6'b000000});
    vecs.push_back('{2'b10, 6'b100000});
    vecs.push_back('{2'b01, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b01, 6'b000000});
    vecs.push_back('{2'b01, 6'b100000});
    vecs.push_back('{2'b00, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b00, 6'b000000});
    // 0.5, then the two no-coin codes, then 1.0
    vecs.push_back('{2'b01, 6'b000000});
    vecs.push_back('{2'b11, 6'b000000});
    vecs.push_back('{2'b00, 6'b000000});
    vecs.push_back('{2'b10, 6'b100000});
    vecs.push_back('{2'b00, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b00, 6'b000000});
    // Back-to-back purchases: 10,01,10,01
    vecs.push_back('{2'b10, 6'b000000});
    vecs.push_back('{2'b01, 6'b100000});
    vecs.push_back('{2'b10, 6'b010101});
    vecs.push_back('{2'b01, 6'b101010});
    vecs.push_back('{2'b00, 6'b010101});
    vecs.push_back('{2'b00, 6'b001010});
    vecs.push_back('{2'b00, 6'b000000});

    Reset = 1'b1;
    D_in  = 2'b00;
    #1 Reset = 1'b0;
    #2;
    check("reset_state", outs(), 6'b000000);
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;

    foreach (vecs[i]) step(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a Moore dispense cycle
    step(2'b10, 6'b000000, "r1_coin1");
    step(2'b10, 6'b100000, "r1_coin2");
    D_in = 2'b00;
    #1;
    check("r1_pre_reset", outs(), 6'b010101);
    #1 Reset = 1'b0;
    #1;
    check("r1_async_clear", outs(), 6'b000000);
    @(posedge Clk);
    #1;
    check("r1_reset_held", outs(), 6'b000000);
    Reset = 1'b1;
    #1;
    step(2'b00, 6'b000000, "r1_after");

    // Reset after 0.5 has been paid. The credit is discarded, so a 1.0 coin
    // must not dispense.
    step(2'b01, 6'b000000, "r2_half");
    #2 Reset = 1'b0;
    #1;
    check("r2_async_clear", outs(), 6'b000000);
    Reset = 1'b1;
    step(2'b10, 6'b000000, "r2_one_no_dispense");
    step(2'b00, 6'b000000, "r2_no_moore");
    step(2'b00, 6'b000000, "r2_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
